// File: rtl/phase_controller.sv
// Multi-cycle instruction phase sequencer (IF/ID/EX/MEM/WB) with continuous run,
// single-step, stop request and absorbing halt, driving phase-gated datapath controls.
module phase_controller #(
  parameter bit          FAST_MODE = 1'b0,
  parameter int unsigned CW        = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          exec,
  input  logic          step,
  input  logic [15:0]   instr,
  input  logic          cond_taken,
  output logic [2:0]    phase,
  output logic          ir_load,
  output logic          pc_inc,
  output logic          RegWrite,
  output logic          MemRead,
  output logic          MemWrite,
  output logic          MemtoReg,
  output logic          RegDst,
  output logic          ALUSrc,
  output logic          PCSrc,
  output logic          running,
  output logic          halted,
  output logic [CW-1:0] retired
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StIf   = 3'd1,
    StId   = 3'd2,
    StEx   = 3'd3,
    StMem  = 3'd4,
    StWb   = 3'd5,
    StHalt = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   ir_q, ir_d;
  logic          single_q, single_d;
  logic          stop_q, stop_d;
  logic [CW-1:0] retired_q, retired_d;

  logic [1:0] op1;
  logic [2:0] op2;
  logic [3:0] op3;
  logic       is_nop, is_ld, is_st, is_li, is_b, is_bc, is_hlt, is_wr;
  logic       in_run;

  assign op1 = ir_q[15:14];
  assign op2 = ir_q[13:11];
  assign op3 = ir_q[7:4];

  // An all-zero word is NOP even though its op1 field would otherwise decode as LD.
  assign is_nop = (ir_q == 16'h0000);
  assign is_ld  = (op1 == 2'b00) && !is_nop;
  assign is_st  = (op1 == 2'b01);
  assign is_li  = (op1 == 2'b10) && (op2 == 3'b000);
  assign is_b   = (op1 == 2'b10) && (op2 == 3'b100);
  assign is_bc  = (op1 == 2'b10) && (op2 == 3'b111);
  assign is_hlt = (op1 == 2'b11) && (op3 == 4'b1111);
  assign is_wr  = is_ld || is_li ||
                  ((op1 == 2'b11) && (op3 != 4'b0101) && (op3 != 4'b1101) && (op3 != 4'b1111));

  assign in_run = (state_q == StIf) || (state_q == StId) || (state_q == StEx) ||
                  (state_q == StMem) || (state_q == StWb);

  always_comb begin
    state_d   = state_q;
    single_d  = single_q;
    stop_d    = stop_q;
    ir_d      = (state_q == StIf) ? instr : ir_q;
    retired_d = (state_q == StWb) ? retired_q + CW'(1) : retired_q;

    unique case (state_q)
      StIdle: begin
        if (exec) begin
          state_d  = StIf;
          single_d = 1'b0;
        end else if (step) begin
          state_d  = StIf;
          single_d = 1'b1;
        end
      end
      StIf:  state_d = StId;
      StId:  state_d = StEx;
      StEx:  state_d = (FAST_MODE && !(is_ld || is_st)) ? StWb : StMem;
      StMem: state_d = StWb;
      StWb: begin
        if (is_hlt) begin
          state_d = StHalt;
        end else if (single_q || stop_q || exec) begin
          state_d = StIdle;
        end else begin
          state_d = StIf;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase

    if (in_run && exec) begin
      stop_d = 1'b1;
    end
    if ((state_d == StIdle) || (state_d == StHalt)) begin
      stop_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      single_q  <= 1'b0;
      stop_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      single_q  <= single_d;
      stop_q    <= stop_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    phase    = state_q;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    PCSrc    = 1'b0;
    running  = in_run;
    halted   = (state_q == StHalt);
    retired  = retired_q;

    // IR is only meaningful once latched, so decoded controls start at ID.
    if ((state_q != StIf) && in_run) begin
      RegDst = !is_ld;
    end
    unique case (state_q)
      StIf: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      StEx:  ALUSrc = is_ld || is_st;
      StMem: begin
        MemRead  = is_ld;
        MemWrite = is_st;
      end
      StWb: begin
        RegWrite = is_wr;
        MemtoReg = is_ld;
        PCSrc    = is_b || (is_bc && cond_taken);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_phase_controller.sv
// Self-checking bench: two controllers (FAST_MODE=0/CW=16 and FAST_MODE=1/CW=2)
// exercised with directed and randomized instruction streams against a spec-level model.
module tb_phase_controller;

  logic        clock = 1'b0;
  logic        reset_n [2];
  logic        exec_s  [2];
  logic        step_s  [2];
  logic        cond_s  [2];
  logic [15:0] instr_s [2];

  wire  [13:0] o0, o1;
  wire  [15:0] r0;
  wire  [1:0]  r1;

  int checks   = 0;
  int failures = 0;
  int ret_m [2];

  always #5 clock = ~clock;

  phase_controller #(.FAST_MODE(1'b0), .CW(16)) dut0 (
    .clock(clock), .reset(reset_n[0]), .exec(exec_s[0]), .step(step_s[0]),
    .instr(instr_s[0]), .cond_taken(cond_s[0]), .phase(o0[13:11]),
    .ir_load(o0[10]), .pc_inc(o0[9]), .RegWrite(o0[8]), .MemRead(o0[7]),
    .MemWrite(o0[6]), .MemtoReg(o0[5]), .RegDst(o0[4]), .ALUSrc(o0[3]),
    .PCSrc(o0[2]), .running(o0[1]), .halted(o0[0]), .retired(r0)
  );

  phase_controller #(.FAST_MODE(1'b1), .CW(2)) dut1 (
    .clock(clock), .reset(reset_n[1]), .exec(exec_s[1]), .step(step_s[1]),
    .instr(instr_s[1]), .cond_taken(cond_s[1]), .phase(o1[13:11]),
    .ir_load(o1[10]), .pc_inc(o1[9]), .RegWrite(o1[8]), .MemRead(o1[7]),
    .MemWrite(o1[6]), .MemtoReg(o1[5]), .RegDst(o1[4]), .ALUSrc(o1[3]),
    .PCSrc(o1[2]), .running(o1[1]), .halted(o1[0]), .retired(r1)
  );

  function automatic logic [13:0] obs(input int sel);
    return (sel == 1) ? o1 : o0;
  endfunction

  function automatic int ret_obs(input int sel);
    return (sel == 1) ? int'(r1) : int'(r0);
  endfunction

  function automatic int ret_exp(input int sel);
    return (sel == 1) ? (ret_m[1] % 4) : (ret_m[0] % 65536);
  endfunction

  function automatic bit mem_op(input logic [15:0] ins);
    return (ins[15:14] == 2'b01) || ((ins[15:14] == 2'b00) && (ins != 16'h0000));
  endfunction

  // Expected output vector for a given phase and the instruction being executed.
  function automatic logic [13:0] exp_vec(input logic [2:0] ph, input logic [15:0] ins,
                                          input logic cond);
    logic ld, st, li, b, bc, rw;
    logic [13:0] e;
    ld = (ins[15:14] == 2'b00) && (ins != 16'h0000);
    st = (ins[15:14] == 2'b01);
    li = (ins[15:11] == 5'b10000);
    b  = (ins[15:11] == 5'b10100);
    bc = (ins[15:11] == 5'b10111);
    rw = ld || li || ((ins[15:14] == 2'b11) && !(ins[7:4] inside {4'h5, 4'hD, 4'hF}));
    e        = '0;
    e[13:11] = ph;
    e[10]    = (ph == 3'd1);
    e[9]     = (ph == 3'd1);
    e[8]     = (ph == 3'd5) && rw;
    e[7]     = (ph == 3'd4) && ld;
    e[6]     = (ph == 3'd4) && st;
    e[5]     = (ph == 3'd5) && ld;
    e[4]     = (ph >= 3'd2) && (ph <= 3'd5) && !ld;
    e[3]     = (ph == 3'd3) && (ld || st);
    e[2]     = (ph == 3'd5) && (b || (bc && cond));
    e[1]     = (ph >= 3'd1) && (ph <= 3'd5);
    e[0]     = (ph == 3'd6);
    return e;
  endfunction

  function automatic logic [15:0] gen_instr();
    logic [15:0] ins;
    ins = 16'($urandom);
    case ($urandom_range(0, 5))
      1: ins[15:11] = 5'b10000;
      2: ins[15:11] = 5'b10100;
      3: ins[15:11] = 5'b10111;
      4: begin
        ins[15:14] = 2'b11;
        if ($urandom_range(0, 1) == 1) ins[7:4] = ($urandom_range(0, 1) == 1) ? 4'h5 : 4'hD;
      end
      5: ins = 16'h0000;
      default: ;
    endcase
    if ((ins[15:14] == 2'b11) && (ins[7:4] == 4'hF)) ins[4] = 1'b0;
    return ins;
  endfunction

  // Called at the falling edge of an IF cycle; walks one instruction through WB,
  // optionally pulsing exec at cycle index stop_k, with random step pulses (ignored).
  task automatic run_instr(input int sel, input logic [15:0] ins, input logic cond,
                           input int stop_k, input string name);
    int          n;
    logic [2:0]  ph;
    logic [13:0] e;
    n = (sel == 1 && !mem_op(ins)) ? 4 : 5;
    instr_s[sel] = ins;
    cond_s[sel]  = cond;
    for (int k = 0; k < n; k++) begin
      ph = (k == n - 1) ? 3'd5 : 3'(k + 1);
      e  = exp_vec(ph, ins, cond);
      checks++;
      if (obs(sel) !== e) begin
        failures++;
        $display("FAIL %s dut%0d cyc%0d outputs got=%h exp=%h", name, sel, k, obs(sel), e);
      end
      checks++;
      if (ret_obs(sel) != ret_exp(sel)) begin
        failures++;
        $display("FAIL %s dut%0d cyc%0d retired got=%0d exp=%0d", name, sel, k,
                 ret_obs(sel), ret_exp(sel));
      end
      exec_s[sel] = (k == stop_k);
      step_s[sel] = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    exec_s[sel] = 1'b0;
    step_s[sel] = 1'b0;
    ret_m[sel]++;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      reset_n[s] = 1'b0;
      exec_s[s]  = 1'b0;
      step_s[s]  = 1'b0;
      cond_s[s]  = 1'b0;
      instr_s[s] = 16'h0000;
      ret_m[s]   = 0;
    end
    repeat (2) @(negedge clock);
    checks++;
    if (o0 !== 14'h0) begin failures++; $display("FAIL reset_out0 got=%h exp=0", o0); end
    checks++;
    if (o1 !== 14'h0) begin failures++; $display("FAIL reset_out1 got=%h exp=0", o1); end
    checks++;
    if (r0 !== 16'h0) begin failures++; $display("FAIL reset_ret0 got=%0d exp=0", r0); end
    checks++;
    if (r1 !== 2'h0) begin failures++; $display("FAIL reset_ret1 got=%0d exp=0", r1); end
  endtask

  // Step is raised together with reset release; the next rising edge must accept it.
  task automatic test_step_nop();
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;
    step_s[0]  = 1'b1;
    @(negedge clock);
    step_s[0] = 1'b0;
    run_instr(0, 16'h0000, 1'b1, -1, "nop_step");
    checks++;
    if (o0[13:11] !== 3'd0) begin failures++; $display("FAIL nop_idle got=%0d exp=0", o0[13:11]); end
    checks++;
    if (r0 !== 16'd1) begin failures++; $display("FAIL nop_ret got=%0d exp=1", r0); end
    step_s[1] = 1'b1;
    @(negedge clock);
    step_s[1] = 1'b0;
    run_instr(1, 16'h0000, 1'b0, -1, "nop_fast");
    checks++;
    if (o1[13:11] !== 3'd0) begin failures++; $display("FAIL nopf_idle got=%0d exp=0", o1[13:11]); end
  endtask

  task automatic test_exec_ld();
    exec_s[0] = 1'b1;
    @(negedge clock);
    exec_s[0] = 1'b0;
    run_instr(0, 16'h0123, 1'($urandom_range(0, 1)), -1, "exec_ld");
    checks++;
    if (o0[13:11] !== 3'd1) begin failures++; $display("FAIL ld_next got=%0d exp=1", o0[13:11]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins;
    for (int i = 0; i < 12; i++) begin
      ins = gen_instr();
      run_instr(0, ins, 1'($urandom_range(0, 1)), (i == 11) ? $urandom_range(0, 3) : -1, "b2b");
      checks++;
      if (o0[13:11] !== ((i == 11) ? 3'd0 : 3'd1)) begin
        failures++;
        $display("FAIL b2b_next i=%0d got=%0d", i, o0[13:11]);
      end
    end
  endtask

  // Exec and step together start a continuous run; exec in EX stops after WB.
  task automatic test_stop();
    exec_s[0] = 1'b1;
    step_s[0] = 1'b1;
    @(negedge clock);
    exec_s[0] = 1'b0;
    step_s[0] = 1'b0;
    run_instr(0, gen_instr(), 1'b0, -1, "both_start");
    checks++;
    if (o0[13:11] !== 3'd1) begin failures++; $display("FAIL both_cont got=%0d exp=1", o0[13:11]); end
    run_instr(0, 16'h8005, 1'b0, 2, "stop_ex");
    checks++;
    if (o0[13:11] !== 3'd0) begin failures++; $display("FAIL stop_idle got=%0d exp=0", o0[13:11]); end
    checks++;
    if (ret_obs(0) != ret_exp(0)) begin
      failures++;
      $display("FAIL stop_ret got=%0d exp=%0d", ret_obs(0), ret_exp(0));
    end
  endtask

  task automatic test_fast();
    step_s[1] = 1'b1;
    @(negedge clock);
    step_s[1] = 1'b0;
    run_instr(1, 16'h8005, 1'b0, -1, "fast_li");
    checks++;
    if (o1[13:11] !== 3'd0) begin failures++; $display("FAIL li_idle got=%0d exp=0", o1[13:11]); end
    step_s[1] = 1'b1;
    @(negedge clock);
    step_s[1] = 1'b0;
    run_instr(1, 16'h4000, 1'b1, -1, "fast_st");
    checks++;
    if (o1[13:11] !== 3'd0) begin failures++; $display("FAIL st_idle got=%0d exp=0", o1[13:11]); end
  endtask

  task automatic test_branch();
    exec_s[0] = 1'b1;
    @(negedge clock);
    exec_s[0] = 1'b0;
    run_instr(0, 16'hB800, 1'b0, -1, "bc_nt");
    run_instr(0, 16'hB800, 1'b1, -1, "bc_t");
    run_instr(0, 16'hA000, 1'b0, -1, "b");
    run_instr(0, 16'hC050, 1'b1, 0, "cmp");
    checks++;
    if (o0[13:11] !== 3'd0) begin failures++; $display("FAIL br_idle got=%0d exp=0", o0[13:11]); end
  endtask

  task automatic test_halt();
    logic [13:0] e;
    step_s[0] = 1'b1;
    @(negedge clock);
    step_s[0] = 1'b0;
    run_instr(0, 16'hC0F0, 1'b0, -1, "hlt");
    e = exp_vec(3'd6, 16'hC0F0, 1'b0);
    checks++;
    if (o0 !== e) begin failures++; $display("FAIL halt_enter got=%h exp=%h", o0, e); end
    exec_s[0] = 1'b1;
    @(negedge clock);
    exec_s[0] = 1'b0;
    step_s[0] = 1'b1;
    @(negedge clock);
    step_s[0] = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (o0 !== e) begin failures++; $display("FAIL halt_stay got=%h exp=%h", o0, e); end
    checks++;
    if (ret_obs(0) != ret_exp(0)) begin
      failures++;
      $display("FAIL halt_ret got=%0d exp=%0d", ret_obs(0), ret_exp(0));
    end
    reset_n[0] = 1'b0;
    #1;
    ret_m[0] = 0;
    checks++;
    if (o0 !== 14'h0) begin failures++; $display("FAIL halt_reset got=%h exp=0", o0); end
    checks++;
    if (r0 !== 16'h0) begin failures++; $display("FAIL halt_reset_ret got=%0d exp=0", r0); end
    @(negedge clock);
    reset_n[0] = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_wrap();
    reset_n[1] = 1'b0;
    @(negedge clock);
    reset_n[1] = 1'b1;
    ret_m[1]   = 0;
    exec_s[1]  = 1'b1;
    @(negedge clock);
    exec_s[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_instr(1, gen_instr(), 1'($urandom_range(0, 1)), (i == 3) ? $urandom_range(0, 2) : -1,
                "wrap");
    end
    checks++;
    if (o1[13:11] !== 3'd0) begin failures++; $display("FAIL wrap_idle got=%0d exp=0", o1[13:11]); end
    checks++;
    if (r1 !== 2'd0) begin failures++; $display("FAIL wrap_ret got=%0d exp=0", r1); end
  endtask

  initial begin
    test_reset();
    test_step_nop();
    test_exec_ld();
    test_back_to_back();
    test_stop();
    test_fast();
    test_branch();
    test_halt();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_controller.md
PHASE_CONTROLLER -- requirements
Module: phase_controller

Interface
REQ-001 Parameter FAST_MODE, default 0; 1 = skip MEM phase for instructions that are not LD/ST.
REQ-002 Parameter CW, default 16; width of retired-instruction counter.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 exec  input  1  one-cycle pulse; start when idle, stop request when running.
REQ-006 step  input  1  one-cycle pulse; run exactly one instruction from IDLE.
REQ-007 instr  input  16  instruction word from instruction memory.
REQ-008 cond_taken  input  1  branch condition from flag unit, sampled in WB.
REQ-009 phase  output  3  state code: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6.
REQ-010 ir_load, pc_inc  output  1 each  IR capture strobe and PC+1 strobe.
REQ-011 RegWrite, MemRead, MemWrite, MemtoReg, RegDst, ALUSrc, PCSrc  output  1 each  phase-gated datapath controls.
REQ-012 running, halted  output  1 each  status flags.
REQ-013 retired  output  CW  count of completed instructions.

Function
REQ-014 Decode SHALL use latched IR fields: op1=IR[15:14], op2=IR[13:11], op3=IR[7:4].
REQ-015 Classes SHALL be: LD op1=00; ST op1=01; LI op1=10,op2=000; B op1=10,op2=100; BC op1=10,op2=111; HLT op1=11,op3=1111; NOP IR=0.
REQ-016 IDLE: exec -> IF (continuous run); step -> IF (single); exec and step together -> exec wins.
REQ-017 Sequence SHALL be IF -> ID -> EX -> MEM -> WB, one cycle each; 5 cycles per instruction.
REQ-018 With FAST_MODE=1, non-LD/ST instructions SHALL go EX -> WB (4 cycles).
REQ-019 IF: ir_load=1 and pc_inc=1 for exactly that cycle; IR captures instr.
REQ-020 EX: ALUSrc=1 for LD/ST, else 0; RegDst=1 except LD, valid ID through WB.
REQ-021 MEM: MemRead=1 for LD only; MemWrite=1 for ST only; both 0 in all other phases.
REQ-022 WB: RegWrite=1 for LD, LI, op1=11 except op3 in {0101 CMP, 1101 OUT, 1111 HLT}; 0 for NOP, ST, B, BC; MemtoReg=1 for LD.
REQ-023 WB: PCSrc=1 for B, or BC with cond_taken=1; PCSrc SHALL be 0 outside WB.
REQ-024 After WB: HLT -> HALT; single-step or pending stop -> IDLE; otherwise -> IF.
REQ-025 exec while running SHALL set a stop-pending flag; current instruction completes; flag clears on entering IDLE.
REQ-026 step while running SHALL be ignored.
REQ-027 HALT SHALL be absorbing; only reset exits; exec/step ignored; halted=1, all strobes 0.
REQ-028 retired SHALL increment by 1 on each WB cycle (including HLT, NOP), wrapping 2^CW-1 -> 0.
REQ-029 running=1 in IF..WB, 0 in IDLE and HALT.

Reset
REQ-030 reset low SHALL immediately force phase=IDLE, IR=0, retired=0, stop-pending=0, all strobes/status 0, regardless of phase.
REQ-031 First exec/step accepted on first rising edge after reset deasserts.

Verification
V1 reset release, step, instr=0x0000 (NOP) -> IF,ID,EX,MEM,WB,IDLE; RegWrite never 1; retired=1.
V2 exec, LD instr 0x0123 -> MemRead=1 in MEM, RegWrite=1 and MemtoReg=1 in WB, ALUSrc=1 in EX; then IF next cycle.
V3 FAST_MODE=1, LI (0x8005) -> 4-cycle instruction, no MEM phase, RegWrite=1 in WB; ST (0x4000) -> MEM present, MemWrite=1, RegWrite=0.
V4 BC (0xB800) with cond_taken=0 then 1 -> PCSrc 0 then 1 in respective WB; CMP (0xC050) -> RegWrite=0.
V5 running, exec pulse during EX -> instruction completes WB, then IDLE; retired incremented once.
V6 HLT (0xC0F0) -> HALT after WB, halted=1, exec ignored; reset low mid-HALT -> IDLE, retired=0; CW=2 run 4 instructions -> retired wraps to 0.
